// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory bus between fetch and data; one transaction in flight, data has priority.
// Latency: request -> mem_req next cycle, rvalid -> registered ack next cycle; requesters stall until ack.
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_flush,
  output logic        inst_ack,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  localparam logic [3:0] STREAK_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] STREAK_SAT = 4'hf;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        drop_q, drop_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_req_q, mem_req_d;
  bus_cmd_t    cmd_q, cmd_d;
  logic        inst_ack_q, inst_ack_d;
  logic        data_ack_q, data_ack_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic inst_elig;
  logic data_elig;
  logic starved;
  logic grant_data;
  logic grant_inst;
  logic inst_flush_hit;

  // A requester whose ack is visible this cycle has already been served.
  assign inst_elig  = inst_req & ~inst_ack_q & ~inst_flush;
  assign data_elig  = data_req & ~data_ack_q;
  assign starved    = (streak_q >= STREAK_LIM);
  assign grant_data = (state_q == IDLE) & data_elig & (~inst_elig | ~starved);
  assign grant_inst = (state_q == IDLE) & inst_elig & (~data_elig | starved);

  assign inst_flush_hit = inst_flush & ~owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      drop_q       <= 1'b0;
      streak_q     <= '0;
      mem_req_q    <= 1'b0;
      cmd_q        <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      drop_q       <= drop_d;
      streak_q     <= streak_d;
      mem_req_q    <= mem_req_d;
      cmd_q        <= cmd_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_data | grant_inst) state_d = ADDR;
      ADDR:    if (mem_gnt) state_d = RESP;
      RESP:    if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    drop_d       = drop_q;
    streak_d     = streak_q;
    mem_req_d    = mem_req_q;
    cmd_d        = cmd_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          owner_d   = 1'b1;
          mem_req_d = 1'b1;
          cmd_d     = '{wen: data_wen, addr: data_addr, wdata: data_wdata};
          if (inst_elig) begin
            streak_d = (streak_q == STREAK_SAT) ? streak_q : streak_q + 4'd1;
          end
        end else if (grant_inst) begin
          owner_d   = 1'b0;
          mem_req_d = 1'b1;
          cmd_d     = '{wen: 4'h0, addr: inst_addr, wdata: 32'h0};
          streak_d  = '0;
        end
      end
      ADDR: begin
        // rvalid cannot legally precede the grant, so it is ignored here.
        if (mem_gnt) mem_req_d = 1'b0;
        if (inst_flush_hit) drop_d = 1'b1;
      end
      RESP: begin
        if (mem_rvalid) begin
          if (owner_q) begin
            data_ack_d   = 1'b1;
            data_rdata_d = mem_rdata;
          end else if (!(drop_q | inst_flush)) begin
            // A redirect arriving with the response makes it stale too.
            inst_ack_d   = 1'b1;
            inst_rdata_d = mem_rdata;
          end
          drop_d = 1'b0;
        end else if (inst_flush_hit) begin
          drop_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_req      = mem_req_q;
  assign mem_wen      = cmd_q.wen;
  assign mem_addr     = cmd_q.addr;
  assign mem_wdata    = cmd_q.wdata;
  assign inst_ack     = inst_ack_q;
  assign data_ack     = data_ack_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign stallreq_if  = inst_req & ~inst_ack_q;
  assign stallreq_mem = data_req & ~data_ack_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter; the bench plays the memory bus by hand.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_flush, inst_ack;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_ack;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stallreq_if, stallreq_mem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; checks happen 1ns after that.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called in an ADDR cycle; returns in the ack cycle.
  task automatic serve(input logic [31:0] rd);
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    chk("serve_req_low_in_resp", mem_req, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    next_cycle();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = 0; inst_flush = 0;
    data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    next_cycle();
    next_cycle();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_inst_ack", inst_ack, 0);
    chk("rst_data_ack", data_ack, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    rst = 1'b0;
    next_cycle();

    // Single fetch: ack in cycle 3, stall cycles 0-2
    inst_req = 1; inst_addr = 32'hbfc00000;
    settle();
    chk("f_stall_c0", stallreq_if, 1);
    chk("f_req_c0", mem_req, 0);
    next_cycle();
    chk("f_req_c1", mem_req, 1);
    chk("f_addr_c1", mem_addr, 32'hbfc00000);
    chk("f_wen_c1", mem_wen, 0);
    mem_gnt = 1;
    next_cycle();
    mem_gnt = 0;
    chk("f_req_c2", mem_req, 0);
    chk("f_ack_c2", inst_ack, 0);
    chk("f_stall_c2", stallreq_if, 1);
    mem_rvalid = 1; mem_rdata = 32'h24010001;
    next_cycle();
    mem_rvalid = 0; mem_rdata = 0;
    chk("f_ack_c3", inst_ack, 1);
    chk("f_rdata_c3", inst_rdata, 32'h24010001);
    chk("f_stall_c3", stallreq_if, 0);
    next_cycle();
    chk("f_ack_c4", inst_ack, 0);
    chk("f_no_regrant_c4", mem_req, 0);
    chk("f_rdata_hold", inst_rdata, 32'h24010001);
    inst_req = 0;
    next_cycle();

    // Store held in ADDR, then gnt with a spurious rvalid, then a load
    data_req = 1; data_wen = 4'hf; data_addr = 32'h80000010; data_wdata = 32'hdeadbeef;
    settle();
    chk("st_stall_mem", stallreq_mem, 1);
    next_cycle();
    chk("st_req", mem_req, 1);
    chk("st_wen", mem_wen, 4'hf);
    chk("st_wdata", mem_wdata, 32'hdeadbeef);
    chk("st_addr", mem_addr, 32'h80000010);
    next_cycle();
    chk("st_req_held", mem_req, 1);
    chk("st_wdata_held", mem_wdata, 32'hdeadbeef);
    mem_gnt = 1; mem_rvalid = 1;
    next_cycle();
    mem_gnt = 0; mem_rvalid = 0;
    chk("st_req_low", mem_req, 0);
    chk("st_early_rvalid_ignored", data_ack, 0);
    next_cycle();
    chk("st_still_waiting", data_ack, 0);
    mem_rvalid = 1;
    next_cycle();
    mem_rvalid = 0;
    chk("st_ack", data_ack, 1);
    chk("st_stall_mem_low", stallreq_mem, 0);
    data_wen = 4'h0;
    next_cycle();
    chk("ld_no_grant_in_ack", mem_req, 0);
    next_cycle();
    chk("ld_req", mem_req, 1);
    chk("ld_wen", mem_wen, 0);
    chk("ld_addr", mem_addr, 32'h80000010);
    serve(32'hdeadbeef);
    chk("ld_ack", data_ack, 1);
    chk("ld_rdata", data_rdata, 32'hdeadbeef);
    data_req = 0;
    next_cycle();

    // Contention: data first, fetch right after data_ack
    inst_req = 1; inst_addr = 32'hbfc00008;
    data_req = 1; data_addr = 32'h80000020;
    next_cycle();
    chk("ct_data_first", mem_addr, 32'h80000020);
    serve(32'h11112222);
    chk("ct_data_ack", data_ack, 1);
    chk("ct_data_rdata", data_rdata, 32'h11112222);
    data_req = 0;
    next_cycle();
    chk("ct_inst_req", mem_req, 1);
    chk("ct_inst_addr", mem_addr, 32'hbfc00008);
    serve(32'h33334444);
    chk("ct_inst_ack", inst_ack, 1);
    chk("ct_inst_rdata", inst_rdata, 32'h33334444);
    inst_req = 0;
    next_cycle();

    // Starvation: redirects during each data ack keep fetch out of the
    // ack-cycle slot, so both contend in IDLE every round.
    inst_req = 1; inst_addr = 32'hbfc00010;
    data_req = 1; data_addr = 32'h80000030;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      chk($sformatf("sv_data_grant_%0d", i), mem_addr, 32'h80000030);
      serve(32'h0);
      chk($sformatf("sv_data_ack_%0d", i), data_ack, 1);
      inst_flush = 1;
      next_cycle();
      inst_flush = 0;
      chk($sformatf("sv_idle_%0d", i), mem_req, 0);
    end
    next_cycle();
    chk("sv_inst_grant", mem_addr, 32'hbfc00010);
    serve(32'h55556666);
    chk("sv_inst_ack", inst_ack, 1);
    chk("sv_inst_rdata", inst_rdata, 32'h55556666);
    inst_req = 0;
    next_cycle();
    chk("sv_data_after", mem_addr, 32'h80000030);
    serve(32'h0);
    data_req = 0;
    next_cycle();
    inst_req = 1; inst_addr = 32'hbfc00020;
    data_req = 1; data_addr = 32'h80000034;
    next_cycle();
    chk("sv_streak_reset_data_first", mem_addr, 32'h80000034);
    serve(32'h0);
    data_req = 0;
    next_cycle();
    chk("sv_inst_follow", mem_addr, 32'hbfc00020);
    serve(32'h77778888);
    inst_req = 0;
    next_cycle();

    // Flush in RESP drops the response; redirected fetch then acks
    inst_req = 1; inst_addr = 32'hbfc00004;
    next_cycle();
    chk("fl_addr", mem_addr, 32'hbfc00004);
    mem_gnt = 1;
    next_cycle();
    mem_gnt = 0;
    inst_flush = 1; inst_addr = 32'hbfc00100;
    next_cycle();
    inst_flush = 0;
    mem_rvalid = 1; mem_rdata = 32'hdeadc0de;
    next_cycle();
    mem_rvalid = 0; mem_rdata = 0;
    chk("fl_no_ack", inst_ack, 0);
    chk("fl_rdata_kept", inst_rdata, 32'h77778888);
    next_cycle();
    chk("fl_refetch_req", mem_req, 1);
    chk("fl_refetch_addr", mem_addr, 32'hbfc00100);
    serve(32'h8c220000);
    chk("fl_refetch_ack", inst_ack, 1);
    chk("fl_refetch_rdata", inst_rdata, 32'h8c220000);
    inst_req = 0;
    next_cycle();

    // Reset in ADDR, then the request is re-arbitrated
    data_req = 1; data_wen = 4'h3; data_addr = 32'h80000040; data_wdata = 32'h12345678;
    next_cycle();
    chk("rs_req_before", mem_req, 1);
    rst = 1;
    next_cycle();
    chk("rs_mem_req", mem_req, 0);
    chk("rs_mem_wen", mem_wen, 0);
    chk("rs_mem_addr", mem_addr, 0);
    chk("rs_data_ack", data_ack, 0);
    chk("rs_inst_ack", inst_ack, 0);
    chk("rs_data_rdata", data_rdata, 0);
    chk("rs_inst_rdata", inst_rdata, 0);
    rst = 0;
    next_cycle();
    chk("rs_regrant_req", mem_req, 1);
    chk("rs_regrant_addr", mem_addr, 32'h80000040);
    chk("rs_regrant_wen", mem_wen, 4'h3);
    serve(32'h0);
    chk("rs_ack", data_ack, 1);
    data_req = 0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
